tdm_demux: RTL and testbench
============================

# tdm_demux

Receive-side time-division demultiplexer: the opposite end of the slot-select multiplexer link. It takes one serial W-bit sample per slot, plus a frame-sync marker asserted in slot 0. It tracks slot position, assembles NCH channel samples per frame, and publishes the complete frame atomically. It also detects loss of frame alignment and recovers from it. It sits between the mux link input pins and downstream per-channel logic.

## Interface
- NCH, default 2: channels per frame; must be at least 2.
- W, default 1: bits per channel sample.
- MISS_MAX, default 3: consecutive missing slot-0 syncs that force loss of lock.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  slot strobe; one slot is consumed per clk cycle with ce=1.
- din  in  W  serial sample for the current slot.
- sync  in  1  frame marker, high in slot 0; sampled only when ce=1.
- dout  out  NCH*W  last complete frame; channel k is at bits [k*W +: W].
- valid  out  1  one-cycle pulse: dout was updated this cycle.
- locked  out  1  high while the block is in the LOCK state.
- slot  out  $clog2(NCH)  index of the next slot to be captured.
- err  out  1  one-cycle pulse on any sync violation.

## Operation
- States are HUNT and LOCK. All state changes occur only on cycles with ce=1; ce=0 cycles hold all state.
- HUNT:
  - din is ignored until ce & sync.
  - On that cycle: shadow[0] <= din, slot <= 1, miss <= 0, state <= LOCK.
- LOCK, on each ce cycle:
  - shadow[slot] <= din.
  - slot advances by 1 and wraps from NCH-1 to 0.
- Frame completion: on a ce cycle with slot == NCH-1 and no violation:
  - dout <= {din, shadow[NCH-2:0]}.
  - valid pulses.
  - Channels 0..NCH-2 come from shadow; channel NCH-1 comes directly from din.
- Sync checks in LOCK apply only on ce cycles.
  - slot==0, sync=1: correct; miss <= 0.
  - slot==0, sync=0 (miss):
    - err pulses and miss increments; the sample is still captured as channel 0.
    - If miss reaches MISS_MAX: state <= HUNT, slot <= 0, miss <= 0.
  - slot!=0, sync=1 (early sync):
    - err pulses; the partial frame is discarded with no valid for it.
    - The block realigns: shadow[0] <= din, slot <= 1, miss <= 0.
    - It stays in LOCK.
- dout holds its value between valid pulses and through HUNT.
- Shadow contents are never visible on dout until a full, violation-free frame completes.

## Timing
- Reset values:
  - dout 0, valid 0, err 0, locked 0, slot 0.
  - Internal: miss 0, state HUNT, shadow 0.
- Reset mid-frame clears everything immediately; the partial frame is lost.
- All outputs are registered.
- dout and valid update one clk after the rising edge that samples the last slot. Latency is 1 cycle from the final sample to the output.
- locked rises one clk after the sync-qualified ce in HUNT. It falls one clk after the ce cycle that produces the MISS_MAX-th miss.
- err coincides with the violating ce cycle plus 1 clk, i.e. in the same cycle the state updates become visible.
- valid and err can both be high in the same cycle only when a slot-0 miss occurs in a frame with NCH==... This cannot happen: a miss is flagged at slot 0, while valid is produced at slot NCH-1. Therefore valid and err are mutually exclusive.
- Back-to-back ce is supported at full clk rate.

## Structure
- Package tdm_pkg contains:
  - The state enum {HUNT, LOCK}.
  - A SLOT_W localparam helper, $clog2(NCH).
  - The default NCH/W/MISS_MAX constants.
- Sub-module tdm_sync_tracker:
  - Owns state, slot counter, miss counter and err.
  - Exports slot, locked, a capture enable, a frame-done strobe and a frame-abort strobe.
- tdm_demux holds the shadow registers and the dout/valid output registers, and instantiates the tracker.

## Test plan
- Normal streaming:
  - Stimulus: reset, then NCH=2, W=1, ce=1 continuously; frames (sync=1, din=1), (sync=0, din=0), repeated 4x.
  - Response: locked rises after the first slot; valid every 2 cycles; dout=2'b01.
- ce gaps:
  - Stimulus: same stream with ce=0 inserted between every slot.
  - Response: identical dout sequence; valid spacing doubles; slot holds during gaps.
- Early sync:
  - Stimulus: NCH=4; sync=1 at slot 2.
  - Response: err pulse; no valid for that frame; slot becomes 1; next clean frame is published correctly.
- Loss of lock:
  - Stimulus: MISS_MAX=3; sync held 0 for 3 consecutive slot-0 positions.
  - Response: three err pulses; locked falls after the third; a subsequent sync relocks and resumes valid.
- Reset mid-frame:
  - Stimulus: assert rst after slot 1 of a 4-channel frame.
  - Response: all outputs 0 asynchronously; no valid until a full frame follows the next sync.
- Wide data:
  - Stimulus: W=8, NCH=3; slots 0xA5, 0x3C, 0xFF.
  - Response: dout=24'hFF3CA5 with a single valid pulse.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// tdm_pkg: shared types and defaults for the TDM receive demultiplexer
package tdm_pkg;
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;
  localparam int NCH_DEF = 2;
  localparam int W_DEF = 1;
  localparam int MISS_MAX_DEF = 3;
  localparam int SLOT_W = $clog2(NCH_DEF);
  function automatic int slot_w(input int nch);
    return $clog2(nch);
  endfunction
endpackage

// File: rtl/tdm_demux_sync_tracker.sv
// tdm_sync_tracker: frame alignment FSM, slot/miss counters and sync violation flag
module tdm_sync_tracker import tdm_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int MISS_MAX = MISS_MAX_DEF,
  localparam int SW = slot_w(NCH),
  localparam int MW = $clog2(MISS_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_i,
  input  logic          sync_i,
  output logic [SW-1:0] slot_o,
  output logic          locked_o,
  output logic          cap_o,
  output logic          done_o,
  output logic          abort_o,
  output logic          err_o
);
  state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d, slot_inc;
  logic [MW-1:0] miss_q, miss_d;
  logic err_q, hunt, last, early, miss, lost;
  assign hunt = state_q == HUNT;
  assign last = slot_q == SW'(NCH - 1);
  assign slot_inc = last ? '0 : slot_q + 1'b1;
  assign early = ce_i && !hunt && sync_i && slot_q != '0;
  assign miss = ce_i && !hunt && !sync_i && slot_q == '0;
  assign lost = miss && miss_q == MW'(MISS_MAX - 1);
  assign cap_o = ce_i && (!hunt || sync_i);
  assign done_o = ce_i && !hunt && !sync_i && last;
  assign abort_o = early;
  assign slot_o = slot_q;
  assign locked_o = state_q == LOCK;
  assign err_o = err_q;
  // A slot-0 miss still advances the frame unless it is the one that drops lock
  always_comb begin
    state_d = !ce_i ? state_q : hunt ? (sync_i ? LOCK : HUNT) : lost ? HUNT : LOCK;
    slot_d = !ce_i ? slot_q : ((hunt && sync_i) || early) ? SW'(1) : (hunt || lost) ? '0 : slot_inc;
    miss_d = !ce_i ? miss_q : (hunt || early || lost || (slot_q == '0 && sync_i)) ? '0 :
             miss ? miss_q + 1'b1 : miss_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= HUNT;
      slot_q <= '0;
      miss_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      miss_q <= miss_d;
      err_q <= early || miss;
    end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: assembles per-slot serial samples into frames and publishes them atomically
module tdm_demux import tdm_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int W = W_DEF,
  parameter int MISS_MAX = MISS_MAX_DEF,
  localparam int SW = slot_w(NCH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [W-1:0]            din,
  input  logic                    sync,
  output logic [NCH*W-1:0]        dout,
  output logic                    valid,
  output logic                    locked,
  output logic [$clog2(NCH)-1:0]  slot,
  output logic                    err
);
  logic [(NCH-1)*W-1:0] shadow_q;
  logic [NCH*W-1:0] dout_q;
  logic [SW-1:0] cap_idx;
  logic valid_q, cap, done, abort;
  tdm_sync_tracker #(.NCH(NCH), .MISS_MAX(MISS_MAX)) u_trk (
    .clk(clk), .rst(rst), .ce_i(ce), .sync_i(sync), .slot_o(slot), .locked_o(locked),
    .cap_o(cap), .done_o(done), .abort_o(abort), .err_o(err)
  );
  assign cap_idx = abort ? '0 : slot;
  // The last channel bypasses the shadow so the frame publishes on its own slot
  always_ff @(posedge clk or posedge rst)
    if (rst) shadow_q <= '0;
    else if (cap)
      for (int i = 0; i < NCH - 1; i++)
        if (cap_idx == SW'(i)) shadow_q[i*W +: W] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= done;
      if (done) dout_q <= {din, shadow_q};
    end
  assign dout = dout_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed and random checks of three demux configurations against a frame-level model
module tb_tdm_demux;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic a_ce = 0, a_sync = 0, a_valid, a_locked, a_err;
  logic [7:0] a_din = 0;
  logic [31:0] a_dout;
  logic [1:0] a_slot;
  logic b_ce = 0, b_sync = 0, b_din = 0, b_valid, b_locked, b_err;
  logic [1:0] b_dout;
  logic [0:0] b_slot;
  logic c_ce = 0, c_sync = 0, c_valid, c_locked, c_err;
  logic [7:0] c_din = 0;
  logic [23:0] c_dout;
  logic [1:0] c_slot;
  int errors = 0, checks = 0;
  tdm_demux #(.NCH(4), .W(8), .MISS_MAX(3)) dut_a (.clk(clk), .rst(rst), .ce(a_ce), .din(a_din),
    .sync(a_sync), .dout(a_dout), .valid(a_valid), .locked(a_locked), .slot(a_slot), .err(a_err));
  tdm_demux #(.NCH(2), .W(1), .MISS_MAX(3)) dut_b (.clk(clk), .rst(rst), .ce(b_ce), .din(b_din),
    .sync(b_sync), .dout(b_dout), .valid(b_valid), .locked(b_locked), .slot(b_slot), .err(b_err));
  tdm_demux #(.NCH(3), .W(8), .MISS_MAX(3)) dut_c (.clk(clk), .rst(rst), .ce(c_ce), .din(c_din),
    .sync(c_sync), .dout(c_dout), .valid(c_valid), .locked(c_locked), .slot(c_slot), .err(c_err));
  bit m_lock = 0, m_valid = 0, m_err = 0;
  logic [7:0] m_frame[$];
  int m_miss = 0;
  logic [31:0] m_dout = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_lock = 0; m_valid = 0; m_err = 0; m_frame = {}; m_miss = 0; m_dout = 0;
  endtask
  // Slot position is simply how many samples of the current frame have been collected
  task automatic model();
    m_valid = 0; m_err = 0;
    if (!a_ce) return;
    if (!m_lock) begin
      if (a_sync) begin m_lock = 1; m_frame = {a_din}; m_miss = 0; end
    end else if (m_frame.size() == 0) begin
      m_frame = {a_din};
      if (a_sync) m_miss = 0;
      else begin
        m_err = 1; m_miss++;
        if (m_miss == 3) begin m_lock = 0; m_frame = {}; m_miss = 0; end
      end
    end else if (a_sync) begin
      m_err = 1; m_frame = {a_din}; m_miss = 0;
    end else begin
      m_frame.push_back(a_din);
      if (m_frame.size() == 4) begin
        for (int k = 0; k < 4; k++) m_dout[k*8 +: 8] = m_frame[k];
        m_valid = 1; m_frame = {};
      end
    end
  endtask
  task automatic chk_a();
    chk("a_dout", a_dout, m_dout);
    chk("a_valid", 32'(a_valid), 32'(m_valid));
    chk("a_err", 32'(a_err), 32'(m_err));
    chk("a_locked", 32'(a_locked), 32'(m_lock));
    chk("a_slot", 32'(a_slot), 32'(m_frame.size()));
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk_a();
  endtask
  task automatic a(input bit ce, input bit s, input logic [7:0] d);
    a_ce = ce; a_sync = s; a_din = d;
    tick();
  endtask
  task automatic chk_b(input bit v, input bit l, input logic [1:0] d, input bit s);
    chk("b_valid", 32'(b_valid), 32'(v));
    chk("b_locked", 32'(b_locked), 32'(l));
    chk("b_dout", 32'(b_dout), 32'(d));
    chk("b_slot", 32'(b_slot), 32'(s));
  endtask
  task automatic bstep(input bit ce, input bit s, input bit d);
    b_ce = ce; b_sync = s; b_din = d;
    tick();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_a();
    chk_b(0, 0, 2'b00, 0);
    chk("c_dout_rst", 32'(c_dout), 0);
    chk("c_flags_rst", 32'({c_valid, c_err, c_locked, c_slot}), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bstep(1, 1, 1); chk_b(0, 1, i == 0 ? 2'b00 : 2'b01, 1);
      bstep(1, 0, 0); chk_b(1, 1, 2'b01, 0);
    end
    for (int i = 0; i < 4; i++) begin
      bstep(1, 1, 1); chk_b(0, 1, 2'b01, 1);
      bstep(0, 0, 0); chk_b(0, 1, 2'b01, 1);
      bstep(1, 0, 0); chk_b(1, 1, 2'b01, 0);
      bstep(0, 1, 1); chk_b(0, 1, 2'b01, 0);
    end
    bstep(1, 1, 0); chk_b(0, 1, 2'b01, 1);
    bstep(1, 0, 1); chk_b(1, 1, 2'b10, 0);
    chk("b_err", 32'(b_err), 0);
    b_ce = 0;
    c_ce = 1; c_sync = 1; c_din = 8'hA5; tick();
    chk("c_valid0", 32'(c_valid), 0); chk("c_slot0", 32'(c_slot), 1);
    c_sync = 0; c_din = 8'h3C; tick();
    chk("c_valid1", 32'(c_valid), 0); chk("c_dout1", 32'(c_dout), 0); chk("c_slot1", 32'(c_slot), 2);
    c_din = 8'hFF; tick();
    chk("c_valid2", 32'(c_valid), 1); chk("c_dout2", 32'(c_dout), 32'h00FF3CA5); chk("c_slot2", 32'(c_slot), 0);
    c_ce = 0; tick();
    chk("c_valid3", 32'(c_valid), 0); chk("c_dout3", 32'(c_dout), 32'h00FF3CA5);
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 4; s++) a(1, s == 0, 8'($urandom));
    a(1, 1, 8'h11); a(1, 0, 8'h22); a(1, 1, 8'h33);
    chk("a_early_err", 32'(a_err), 1); chk("a_early_slot", 32'(a_slot), 1);
    a(1, 0, 8'h44); a(1, 0, 8'h55); a(1, 0, 8'h66);
    chk("a_realign_dout", a_dout, 32'h66554433);
    for (int m = 0; m < 3; m++)
      for (int s = 0; s < 4; s++) a(1, 0, 8'($urandom));
    chk("a_lost", 32'(a_locked), 0);
    for (int s = 0; s < 4; s++) a(1, s == 0, 8'h70 + 8'(s));
    chk("a_relock_dout", a_dout, 32'h73727170);
    a(1, 1, 8'h01); a(1, 0, 8'h02);
    rst = 1'b1; model_reset(); #2;
    chk_a();
    chk("a_rst_outs", {a_dout[30:0], a_valid}, 0);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) a(1, 0, 8'($urandom));
    for (int s = 0; s < 4; s++) a(1, s == 0, 8'($urandom));
    for (int i = 0; i < 2000; i++)
      a($urandom_range(0, 3) != 0, (m_frame.size() == 0) ^ ($urandom_range(0, 9) == 0), 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
